mem_access: RTL and testbench
=============================

// Module: mem_access
// PURPOSE
//  MEM-stage data-memory access unit of the 5-stage MIPS pipeline. Turns EX/MEM load/store fields into an
//  SRAM-like req/addr_ok/data_ok bus transaction, aligns load/store data, and drives mem_stall to the hazard
//  control unit, which zeroes all pipeline enables while it is high. Result feeds the MEM/WB register.
// PARAMETERS
//  ADDR_W  32  byte-address width on bus and pipeline side
// PORTS
//  clk          in   1       pipeline clock
//  rst          in   1       synchronous, active-high reset
//  mem_type     in   2       from EX/MEM: `MEM_NOOP / `MEM_LOAD / `MEM_STOR (common.vh encodings)
//  mem_size     in   2       0=byte 1=half 2=word (3 illegal, treated as word)
//  mem_signed   in   1       load sign-extends when 1, zero-extends when 0
//  mem_addr     in   ADDR_W  effective byte address
//  mem_wdata    in   32      store data, right-justified
//  mem_rdata    out  32      aligned/extended load result, valid in DONE
//  mem_stall    out  1       to hazard control; high while access is outstanding
//  addr_error   out  1       misaligned access (AdEL/AdES), combinational
//  data_req     out  1       bus request
//  data_wr      out  1       1=store 0=load
//  data_size    out  2       copy of mem_size
//  data_addr    out  ADDR_W  copy of mem_addr (low bits unmasked)
//  data_wdata   out  32      lane-replicated store data
//  data_addr_ok in   1       slave accepted request this cycle
//  data_data_ok in   1       read data returned / write completed this cycle
//  data_rdata   in   32      raw word read data
// BEHAVIOUR
//  States IDLE, ADDR, DATA, DONE. Reset: IDLE, data_req=0, mem_rdata=0, mem_stall=0.
//  access = mem_type in {LOAD,STOR} && !addr_error. addr_error = (half && a[0]) || (word && a[1:0]!=0).
//  IDLE: access -> data_req=1, mem_stall=1 (combinational, same cycle); addr_ok&data_ok -> DONE;
//    addr_ok only -> DATA; else -> ADDR. No access -> stay IDLE, stall=0, req=0.
//  ADDR: req=1, stall=1, bus outputs held stable; addr_ok&data_ok -> DONE; addr_ok -> DATA.
//  DATA: req=0, stall=1; data_ok -> DONE. addr_ok ignored outside request cycles.
//  DONE: req=0, stall=0 for exactly one cycle; pipeline advances on this edge; -> IDLE unconditionally.
//    Same instruction is never reissued; next MEM instruction may issue in the following IDLE cycle.
//  Load data: registered on data_ok edge. Byte lane = a[1:0]; half lane = a[1]; extend per mem_signed.
//  Store data: byte -> {4{b}}, half -> {2{h}}, word -> as is. Stores write 0-extended nothing to mem_rdata.
//  Minimum latency: 1 stall cycle (addr_ok&data_ok in issue cycle); mem_rdata valid in DONE cycle.
//  addr_error: no request, no stall; downstream exception logic kills the instruction.
//  mem_type of 2'b11 treated as NOOP. Inputs assumed stable while mem_stall=1 (EX/MEM frozen).
//  rst mid-transaction: -> IDLE next edge, req dropped; slave shares rst, so no late data_ok is honoured.
// STRUCTURE
//  mem_pkg: mem_size_t {SZ_BYTE,SZ_HALF,SZ_WORD}, mem_state_t {IDLE,ADDR,DATA,DONE}; reuse `MEM_* from common.vh.
//  Sub-module mem_align: combinational store lane replication + load extract/extend; FSM and rdata reg in top.
// TESTING
//  Word load @0x100, slave addr_ok&data_ok same cycle, rdata=0xDEADBEEF -> stall 1 cycle, mem_rdata=0xDEADBEEF in DONE.
//  Signed byte load @0x103, rdata=0x80FFFFFF -> mem_rdata=0xFFFFFF80; unsigned -> 0x00000080.
//  Half store 0x1234 @0x102, addr_ok delayed 3 cycles, data_ok 2 later -> req high 4 cycles, wdata=0x12341234, stall 6 cycles.
//  Word load @0x101 -> addr_error=1, data_req=0, mem_stall=0.
//  Back-to-back loads -> each issues once; DONE then IDLE re-issue, never duplicate req.
//  rst asserted in DATA -> next cycle IDLE, stall=0, req=0, mem_rdata=0.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and encodings for the MEM-stage data-memory access unit.
// Holds the pipeline mem_type encodings, access sizes and FSM states.
package mem_pkg;

    localparam logic [1:0] MEM_NOOP = 2'b00;
    localparam logic [1:0] MEM_LOAD = 2'b01;
    localparam logic [1:0] MEM_STOR = 2'b10;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } mem_state_t;

endpackage

// File: rtl/mem_access_align.sv
// Combinational data alignment: store lane replication and load lane extract/extend.
// Size encoding 3 falls through to the word path.
module mem_align
    import mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_raw_i,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rdata_raw_i[7:0];
        case (addr_lo_i)
            2'd1:    byte_v = rdata_raw_i[15:8];
            2'd2:    byte_v = rdata_raw_i[23:16];
            2'd3:    byte_v = rdata_raw_i[31:24];
            default: byte_v = rdata_raw_i[7:0];
        endcase
        half_v = addr_lo_i[1] ? rdata_raw_i[31:16] : rdata_raw_i[15:0];
    end

    always_comb begin
        wdata_o = wdata_i;
        rdata_o = rdata_raw_i;
        case (mem_size_t'(size_i))
            SZ_BYTE: begin
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{signed_i & byte_v[7]}}, byte_v};
            end
            SZ_HALF: begin
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{signed_i & half_v[15]}}, half_v};
            end
            default: begin
                wdata_o = wdata_i;
                rdata_o = rdata_raw_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM-stage access unit: drives one req/addr_ok/data_ok transaction per load/store
// and holds the pipeline with mem_stall until the DONE cycle.
module mem_access
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mem_type,
    input  logic [1:0]        mem_size,
    input  logic              mem_signed,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_stall,
    output logic              addr_error,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata,
    output mem_state_t        dbg_state_o
);

    mem_state_t  state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] load_data;
    logic        is_load, is_stor, is_mem, access;

    assign is_load = (mem_type == MEM_LOAD);
    assign is_stor = (mem_type == MEM_STOR);
    assign is_mem  = is_load | is_stor;

    // Misalignment only means something for a real access; size 3 is checked as a word.
    assign addr_error = is_mem &&
                        (((mem_size == SZ_HALF) && mem_addr[0]) ||
                         ((mem_size != SZ_BYTE) && (mem_size != SZ_HALF) && (mem_addr[1:0] != 2'b00)));
    assign access = is_mem && !addr_error;

    mem_align u_align (
        .size_i      (mem_size),
        .signed_i    (mem_signed),
        .addr_lo_i   (mem_addr[1:0]),
        .wdata_i     (mem_wdata),
        .rdata_raw_i (data_rdata),
        .wdata_o     (data_wdata),
        .rdata_o     (load_data)
    );

    // Handshake: a request is accepted on any edge where data_req && data_addr_ok;
    // data_ok closes the access and may coincide with the accepting edge.
    always_comb begin
        state_d   = state_q;
        data_req  = 1'b0;
        mem_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    data_req  = 1'b1;
                    mem_stall = 1'b1;
                    if (data_addr_ok) state_d = data_data_ok ? DONE : DATA;
                    else              state_d = ADDR;
                end
            end
            ADDR: begin
                data_req  = 1'b1;
                mem_stall = 1'b1;
                if (data_addr_ok) state_d = data_data_ok ? DONE : DATA;
            end
            DATA: begin
                mem_stall = 1'b1;
                if (data_data_ok) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture on the completing edge only; stores leave zero in the result register.
    always_comb begin
        rdata_d = rdata_q;
        if ((state_d == DONE) && (state_q != DONE)) begin
            rdata_d = is_load ? load_data : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_rdata   = rdata_q;
    assign data_wr     = is_stor;
    assign data_size   = mem_size;
    assign data_addr   = mem_addr;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: table of transactions against a bench-driven
// slave, plus hand-written reset, misalignment and reset-in-DATA sequences.
module tb_mem_access;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mem_type;
    logic [1:0]  mem_size;
    logic        mem_signed;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        addr_error;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    mem_state_t  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [1:0]  mtype;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          aok;
        int          dok;
        logic [31:0] exp_rdata;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[$];

    mem_access #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_type     (mem_type),
        .mem_size     (mem_size),
        .mem_signed   (mem_signed),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_stall    (mem_stall),
        .addr_error   (addr_error),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .dbg_state_o  (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] mtype, input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                                input int aok, input int dok,
                                input logic [31:0] exp_rdata, input logic [31:0] exp_wdata);
        vec_t v;
        v.mtype = mtype; v.size = size; v.sgn = sgn; v.addr = addr;
        v.wdata = wdata; v.rdata = rdata; v.aok = aok; v.dok = dok;
        v.exp_rdata = exp_rdata; v.exp_wdata = exp_wdata;
        return v;
    endfunction

    // Reference little-endian load: shift the lane down, then extend.
    function automatic logic [31:0] model_load(input logic [1:0] size, input logic sgn,
                                               input logic [1:0] a, input logic [31:0] raw);
        logic [31:0] sh;
        sh = raw >> (8 * a);
        if (size == 2'd0) return sgn ? {{24{sh[7]}}, sh[7:0]} : {24'd0, sh[7:0]};
        if (size == 2'd1) return sgn ? {{16{sh[15]}}, sh[15:0]} : {16'd0, sh[15:0]};
        return raw;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] w);
        if (size == 2'd0) return {w[7:0], w[7:0], w[7:0], w[7:0]};
        if (size == 2'd1) return {w[15:0], w[15:0]};
        return w;
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        mem_type = MEM_NOOP;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive one access and act as slave: addr_ok on request cycle number aok,
    // data_ok dok cycles after acceptance (0 = same cycle).
    task automatic run_txn(input vec_t v, input string tag);
        int c, req_n, stall_n, acc_c;
        bit done;
        logic [31:0] wd;
        exp_q.push_back(v.exp_rdata);
        @(negedge clk);
        mem_type = v.mtype; mem_size = v.size; mem_signed = v.sgn;
        mem_addr = v.addr; mem_wdata = v.wdata; data_rdata = v.rdata;
        c = 0; req_n = 0; stall_n = 0; acc_c = -1; done = 1'b0; wd = '0;
        while (!done && c < 64) begin
            #1;
            if (!mem_stall) begin
                done = 1'b1;
            end else begin
                if (data_req) begin
                    wd = data_wdata;
                    if (acc_c < 0 && req_n == v.aok) acc_c = c;
                    req_n++;
                end
                data_addr_ok = (acc_c == c);
                data_data_ok = (acc_c >= 0) && (c == acc_c + v.dok);
                stall_n++;
                @(negedge clk);
                data_addr_ok = 1'b0;
                data_data_ok = 1'b0;
                c++;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: no DONE within 64 cycles", tag);
            void'(exp_q.pop_front());
            apply_reset();
        end else begin
            check({tag, "_rdata"}, mem_rdata, exp_q.pop_front());
            check({tag, "_req_cycles"}, 32'(req_n), 32'(v.aok + 1));
            check({tag, "_stall_cycles"}, 32'(stall_n), 32'(v.aok + v.dok + 1));
            check({tag, "_done_req"}, {31'd0, data_req}, 32'd0);
            check({tag, "_done_state"}, {30'd0, dbg_state}, {30'd0, DONE});
            if (v.mtype == MEM_STOR) check({tag, "_wdata"}, wd, v.exp_wdata);
        end
    endtask

    initial begin
        mem_type = MEM_NOOP; mem_size = 2'd2; mem_signed = 1'b0;
        mem_addr = '0; mem_wdata = '0; data_rdata = '0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0;
        apply_reset();
        #1;
        check("reset_req", {31'd0, data_req}, 32'd0);
        check("reset_stall", {31'd0, mem_stall}, 32'd0);
        check("reset_rdata", mem_rdata, 32'd0);
        check("reset_state", {30'd0, dbg_state}, {30'd0, IDLE});

        vecs.push_back(mk(MEM_LOAD, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 32'h0));
        vecs.push_back(mk(MEM_LOAD, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80FFFFFF, 0, 0, 32'hFFFFFF80, 32'h0));
        vecs.push_back(mk(MEM_LOAD, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80FFFFFF, 0, 0, 32'h00000080, 32'h0));
        vecs.push_back(mk(MEM_STOR, 2'd1, 1'b0, 32'h102, 32'h00001234, 32'h0, 3, 2, 32'h0, 32'h12341234));
        vecs.push_back(mk(MEM_LOAD, 2'd1, 1'b1, 32'h102, 32'h0, 32'h80017FFF, 1, 1, 32'hFFFF8001, 32'h0));
        vecs.push_back(mk(MEM_LOAD, 2'd1, 1'b0, 32'h100, 32'h0, 32'h8001F00F, 0, 2, 32'h0000F00F, 32'h0));
        vecs.push_back(mk(MEM_STOR, 2'd0, 1'b0, 32'h101, 32'h000000A5, 32'h0, 2, 0, 32'h0, 32'hA5A5A5A5));
        vecs.push_back(mk(MEM_STOR, 2'd2, 1'b0, 32'h104, 32'hCAFEF00D, 32'h0, 0, 1, 32'h0, 32'hCAFEF00D));
        vecs.push_back(mk(MEM_LOAD, 2'd0, 1'b1, 32'h101, 32'h0, 32'h12347F56, 0, 0, 32'h0000007F, 32'h0));
        vecs.push_back(mk(MEM_LOAD, 2'd3, 1'b1, 32'h108, 32'h0, 32'h55AA55AA, 1, 0, 32'h55AA55AA, 32'h0));
        for (int i = 0; i < 6; i++) begin
            logic [1:0]  sz;
            logic [1:0]  off;
            logic [31:0] raw, wdat, addr;
            logic        sgn, ld;
            sz   = 2'($urandom_range(0, 2));
            off  = (sz == 2'd0) ? 2'($urandom_range(0, 3)) : (sz == 2'd1) ? {1'($urandom_range(0, 1)), 1'b0} : 2'd0;
            addr = 32'h400 + 32'($urandom_range(0, 63)) * 4 + {30'd0, off};
            raw  = $urandom;
            wdat = $urandom;
            sgn  = 1'($urandom_range(0, 1));
            ld   = 1'($urandom_range(0, 1));
            vecs.push_back(mk(ld ? MEM_LOAD : MEM_STOR, sz, sgn, addr, wdat, raw,
                              $urandom_range(0, 3), $urandom_range(0, 3),
                              ld ? model_load(sz, sgn, off, raw) : 32'd0, model_wdata(sz, wdat)));
        end

        // Back-to-back: each vector starts the cycle after the previous DONE.
        foreach (vecs[i]) run_txn(vecs[i], $sformatf("v%0d", i));

        @(negedge clk);
        mem_type = MEM_LOAD; mem_size = 2'd2; mem_addr = 32'h101;
        #1;
        check("misalign_word_err", {31'd0, addr_error}, 32'd1);
        check("misalign_word_req", {31'd0, data_req}, 32'd0);
        check("misalign_word_stall", {31'd0, mem_stall}, 32'd0);
        mem_type = MEM_STOR; mem_size = 2'd1; mem_addr = 32'h103;
        #1;
        check("misalign_half_err", {31'd0, addr_error}, 32'd1);
        check("misalign_half_req", {31'd0, data_req}, 32'd0);
        @(negedge clk);
        mem_type = 2'b11; mem_size = 2'd2; mem_addr = 32'h100;
        #1;
        check("type11_req", {31'd0, data_req}, 32'd0);
        check("type11_stall", {31'd0, mem_stall}, 32'd0);
        @(negedge clk);
        #1;
        check("type11_state", {30'd0, dbg_state}, {30'd0, IDLE});

        // Reset while waiting for data_ok must abandon the access and clear the result.
        run_txn(mk(MEM_LOAD, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 32'h0), "pre_rst");
        @(negedge clk);
        mem_type = MEM_LOAD; mem_size = 2'd2; mem_addr = 32'h200; data_rdata = 32'h11111111;
        #1;
        data_addr_ok = 1'b1;
        @(negedge clk);
        data_addr_ok = 1'b0;
        #1;
        check("rstdata_state", {30'd0, dbg_state}, {30'd0, DATA});
        check("rstdata_stall", {31'd0, mem_stall}, 32'd1);
        check("rstdata_req", {31'd0, data_req}, 32'd0);
        check("rstdata_hold", mem_rdata, 32'hDEADBEEF);
        rst = 1'b1;
        mem_type = MEM_NOOP;
        @(negedge clk);
        #1;
        check("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
        check("rst_stall", {31'd0, mem_stall}, 32'd0);
        check("rst_req", {31'd0, data_req}, 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
